// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle RV32I-subset control path: FSM states,
// opcode/funct constants, ALU operation codes and datapath mux encodings.
package cpu_pkg;

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEM_ADR = 4'd2,
        MEM_RD  = 4'd3,
        MEM_WB  = 4'd4,
        MEM_WR  = 4'd5,
        EXEC_R  = 4'd6,
        EXEC_I  = 4'd7,
        ALU_WB  = 4'd8,
        BRANCH  = 4'd9,
        TRAP    = 4'd10
    } state_t;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    localparam logic [2:0] F3_ADDSUB = 3'b000;
    localparam logic [2:0] F3_SLL    = 3'b001;
    localparam logic [2:0] F3_WORD   = 3'b010;
    localparam logic [2:0] F3_XOR    = 3'b100;
    localparam logic [2:0] F3_OR     = 3'b110;
    localparam logic [2:0] F3_AND    = 3'b111;
    localparam logic [2:0] F3_BEQ    = 3'b000;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // ALU operation codes, shared with the ALU itself.
    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;
    localparam logic [3:0] ALU_XOR = 4'b0100;
    localparam logic [3:0] ALU_SLL = 4'b0101;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_REGA  = 2'b10;

    localparam logic [1:0] SRCB_REGB = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_MEM    = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    function automatic logic funct3_is_alu(input logic [2:0] funct3);
        return (funct3 == F3_ADDSUB) || (funct3 == F3_SLL) || (funct3 == F3_XOR)
            || (funct3 == F3_OR) || (funct3 == F3_AND);
    endfunction

    function automatic logic [3:0] alu_op_for(input logic [2:0] funct3, input logic sub);
        case (funct3)
            F3_ADDSUB: return sub ? ALU_SUB : ALU_ADD;
            F3_AND:    return ALU_AND;
            F3_OR:     return ALU_OR;
            F3_XOR:    return ALU_XOR;
            F3_SLL:    return ALU_SLL;
            default:   return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational instruction decode: ALU operation for R/I-type instructions and
// a flag for any opcode/funct combination outside the supported subset.
module alu_decoder
    import cpu_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       instr30,
    input  logic [6:0] funct7,
    output logic [3:0] alu_control,
    output logic       op_illegal
);

    always_comb begin
        alu_control = ALU_ADD;
        op_illegal  = 1'b1;
        case (opcode)
            OP_R: begin
                alu_control = alu_op_for(funct3, instr30);
                if (funct7 == F7_BASE)
                    op_illegal = !funct3_is_alu(funct3);
                else if (funct7 == F7_ALT && funct3 == F3_ADDSUB)
                    op_illegal = 1'b0;
            end
            OP_I: begin
                // instr[30] is immediate data here, so it never selects SUB.
                alu_control = alu_op_for(funct3, 1'b0);
                op_illegal  = !funct3_is_alu(funct3)
                           || (funct3 == F3_SLL && funct7 != F7_BASE);
            end
            OP_LW, OP_SW: op_illegal = (funct3 != F3_WORD);
            OP_BEQ:       op_illegal = (funct3 != F3_BEQ);
            default:      op_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle FSM sequencing fetch/decode/execute/memory/writeback for the
// RV32I-subset datapath, with stallable req/ready memory accesses.
module multicycle_control
    import cpu_pkg::*;
#(
    parameter logic [3:0] RESET_STATE = 4'd0
)
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        adr_src,
    output logic        ir_write,
    output logic        pc_write,
    output logic        reg_write,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  result_src,
    output logic [3:0]  alu_control,
    output logic        illegal,
    output logic [3:0]  state
);

    state_t     cur;
    state_t     nxt;
    logic       started;
    logic [3:0] dec_alu;
    logic       dec_illegal;
    logic       unused_instr_bits;

    assign unused_instr_bits = ^{instr[24:15], instr[11:7]};
    assign state = cur;

    alu_decoder u_alu_decoder (
        .opcode      (instr[6:0]),
        .funct3      (instr[14:12]),
        .instr30     (instr[30]),
        .funct7      (instr[31:25]),
        .alu_control (dec_alu),
        .op_illegal  (dec_illegal)
    );

    // started holds off every request until rst_n has been sampled high once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur     <= state_t'(RESET_STATE);
            started <= 1'b0;
        end else if (!started) begin
            started <= 1'b1;
        end else begin
            cur <= nxt;
        end
    end

    always_comb begin
        nxt = cur;
        case (cur)
            FETCH:   if (mem_ready) nxt = DECODE;
            DECODE: begin
                if (dec_illegal) nxt = TRAP;
                else begin
                    case (instr[6:0])
                        OP_LW, OP_SW: nxt = MEM_ADR;
                        OP_R:         nxt = EXEC_R;
                        OP_I:         nxt = EXEC_I;
                        OP_BEQ:       nxt = BRANCH;
                        default:      nxt = TRAP;
                    endcase
                end
            end
            MEM_ADR: nxt = (instr[6:0] == OP_LW) ? MEM_RD : MEM_WR;
            MEM_RD:  if (mem_ready) nxt = MEM_WB;
            MEM_WB:  nxt = FETCH;
            MEM_WR:  if (mem_ready) nxt = FETCH;
            EXEC_R:  nxt = ALU_WB;
            EXEC_I:  nxt = ALU_WB;
            ALU_WB:  nxt = FETCH;
            BRANCH:  nxt = FETCH;
            TRAP:    nxt = TRAP;
            default: nxt = FETCH;
        endcase
    end

    always_comb begin
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        adr_src     = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        reg_write   = 1'b0;
        alu_src_a   = SRCA_PC;
        alu_src_b   = SRCB_REGB;
        result_src  = RES_ALUOUT;
        alu_control = ALU_ADD;
        illegal     = 1'b0;
        case (cur)
            FETCH: begin
                mem_req    = 1'b1;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALU;
                ir_write   = mem_ready;
                pc_write   = mem_ready;
            end
            DECODE: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
            end
            MEM_ADR: begin
                alu_src_a = SRCA_REGA;
                alu_src_b = SRCB_IMM;
            end
            MEM_RD: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
            end
            MEM_WB: begin
                result_src = RES_MEM;
                reg_write  = 1'b1;
            end
            MEM_WR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                adr_src = 1'b1;
            end
            EXEC_R: begin
                alu_src_a   = SRCA_REGA;
                alu_src_b   = SRCB_REGB;
                alu_control = dec_alu;
            end
            EXEC_I: begin
                alu_src_a   = SRCA_REGA;
                alu_src_b   = SRCB_IMM;
                alu_control = dec_alu;
            end
            ALU_WB:  reg_write = 1'b1;
            BRANCH: begin
                alu_src_a   = SRCA_REGA;
                alu_src_b   = SRCB_REGB;
                alu_control = ALU_SUB;
                pc_write    = zero;
            end
            TRAP:    illegal = 1'b1;
            default: ;
        endcase
        if (!started) begin
            {mem_req, mem_we, ir_write, pc_write, reg_write, illegal} = '0;
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench: each instruction is expanded into its expected per-cycle control
// word sequence, which a single loop drives and compares against the DUT.
module tb_multicycle_control;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr;
    logic        zero;
    logic        mem_ready;
    logic        mem_req, mem_we, adr_src, ir_write, pc_write, reg_write, illegal;
    logic [1:0]  alu_src_a, alu_src_b, result_src;
    logic [3:0]  alu_control, state;

    multicycle_control #(.RESET_STATE(4'd0)) dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .adr_src(adr_src), .ir_write(ir_write),
        .pc_write(pc_write), .reg_write(reg_write), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .result_src(result_src), .alu_control(alu_control),
        .illegal(illegal), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] st;
        logic       mreq, mwe, asrc, irw, pcw, rw;
        logic [1:0] a, b, rs;
        logic [3:0] aluc;
        logic       ill;
    } outs_t;

    typedef struct {
        logic [31:0] ins;
        logic        rdy;
        logic        z;
        outs_t       exp;
    } cyc_t;

    typedef enum {K_R, K_I, K_LW, K_SW, K_BEQ, K_BAD} kind_t;

    cyc_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [3:0] last_exec_alu;
    logic       last_branch_pcw;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic outs_t dut_outs();
        outs_t o;
        o = '{st: state, mreq: mem_req, mwe: mem_we, asrc: adr_src, irw: ir_write,
              pcw: pc_write, rw: reg_write, a: alu_src_a, b: alu_src_b,
              rs: result_src, aluc: alu_control, ill: illegal};
        return o;
    endfunction

    // Control word for a numbered step of the instruction flow.
    function automatic outs_t step(input int st, input logic rdy, input logic z, input logic [3:0] op);
        outs_t o;
        o = '0;
        o.st = 4'(st);
        case (st)
            0:  begin o.mreq = 1; o.b = 2'd2; o.rs = 2'd2; o.irw = rdy; o.pcw = rdy; end
            1:  begin o.a = 2'd1; o.b = 2'd1; end
            2:  begin o.a = 2'd2; o.b = 2'd1; end
            3:  begin o.mreq = 1; o.asrc = 1; end
            4:  begin o.rs = 2'd1; o.rw = 1; end
            5:  begin o.mreq = 1; o.mwe = 1; o.asrc = 1; end
            6:  begin o.a = 2'd2; o.b = 2'd0; o.aluc = op; end
            7:  begin o.a = 2'd2; o.b = 2'd1; o.aluc = op; end
            8:  o.rw = 1;
            9:  begin o.a = 2'd2; o.b = 2'd0; o.aluc = 4'd1; o.pcw = z; end
            10: o.ill = 1;
            default: ;
        endcase
        return o;
    endfunction

    function automatic outs_t idle_fetch();
        outs_t o;
        o = '0;
        o.b = 2'd2;
        o.rs = 2'd2;
        return o;
    endfunction

    function automatic logic [3:0] op_of(input logic [2:0] f3, input logic sub);
        case (f3)
            3'd0: return sub ? 4'd1 : 4'd0;
            3'd7: return 4'd2;
            3'd6: return 4'd3;
            3'd4: return 4'd4;
            default: return 4'd5;
        endcase
    endfunction

    function automatic kind_t classify(input logic [31:0] ins);
        logic [2:0] f3;
        logic [6:0] f7;
        logic       alu_f3;
        f3 = ins[14:12];
        f7 = ins[31:25];
        alu_f3 = (f3 == 0 || f3 == 1 || f3 == 4 || f3 == 6 || f3 == 7);
        case (ins[6:0])
            7'h33: return ((f7 == 0 && alu_f3) || (f7 == 7'h20 && f3 == 0)) ? K_R : K_BAD;
            7'h13: return (alu_f3 && !(f3 == 1 && f7 != 0)) ? K_I : K_BAD;
            7'h03: return (f3 == 2) ? K_LW : K_BAD;
            7'h23: return (f3 == 2) ? K_SW : K_BAD;
            7'h63: return (f3 == 0) ? K_BEQ : K_BAD;
            default: return K_BAD;
        endcase
    endfunction

    task automatic push(input logic [31:0] ins, input logic rdy, input logic z, input outs_t e);
        cyc_t c;
        c.ins = ins; c.rdy = rdy; c.z = z; c.exp = e;
        q.push_back(c);
    endtask

    // mem_ready and zero are held at 1 outside the states that may use them.
    task automatic add_instr(input logic [31:0] ins, input int fw, input int mw,
                             input logic z, input int trap_cycles);
        kind_t      k;
        logic [3:0] op;
        k = classify(ins);
        op = op_of(ins[14:12], (k == K_R) && ins[30]);
        for (int i = 0; i < fw; i++) push(ins, 0, 1, step(0, 0, 1, 0));
        push(ins, 1, 1, step(0, 1, 1, 0));
        push(ins, 1, 1, step(1, 1, 1, 0));
        case (k)
            K_R:  begin push(ins, 1, 1, step(6, 1, 1, op)); push(ins, 1, 1, step(8, 1, 1, 0)); end
            K_I:  begin push(ins, 1, 1, step(7, 1, 1, op)); push(ins, 1, 1, step(8, 1, 1, 0)); end
            K_LW: begin
                push(ins, 1, 1, step(2, 1, 1, 0));
                for (int i = 0; i < mw; i++) push(ins, 0, 1, step(3, 0, 1, 0));
                push(ins, 1, 1, step(3, 1, 1, 0));
                push(ins, 1, 1, step(4, 1, 1, 0));
            end
            K_SW: begin
                push(ins, 1, 1, step(2, 1, 1, 0));
                for (int i = 0; i < mw; i++) push(ins, 0, 1, step(5, 0, 1, 0));
                push(ins, 1, 1, step(5, 1, 1, 0));
            end
            K_BEQ: push(ins, 1, z, step(9, 1, z, 0));
            default: for (int i = 0; i < trap_cycles; i++) push(ins, 1, 1, step(10, 1, 1, 0));
        endcase
    endtask

    task automatic run_queue(output int cycles, output int rws);
        cyc_t  c;
        outs_t got;
        cycles = 0;
        rws = 0;
        while (q.size() > 0) begin
            c = q.pop_front();
            @(negedge clk);
            instr = c.ins; mem_ready = c.rdy; zero = c.z;
            #1;
            got = dut_outs();
            check($sformatf("cycle st%0d instr %h", c.exp.st, c.ins), {11'b0, got}, {11'b0, c.exp});
            if (state == 4'd6 || state == 4'd7) last_exec_alu = alu_control;
            if (state == 4'd9) last_branch_pcw = pc_write;
            cycles++;
            rws += int'(reg_write);
        end
    endtask

    task automatic expect_fetch_next(input string name);
        @(posedge clk);
        #1;
        check(name, {28'b0, state}, 32'd0);
    endtask

    task automatic reset_pulse(input string name);
        rst_n = 1'b0;
        #1;
        check({name, " in reset"}, {11'b0, dut_outs()}, {11'b0, idle_fetch()});
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check({name, " released unsampled"}, {11'b0, dut_outs()}, {11'b0, idle_fetch()});
        @(posedge clk);
    endtask

    logic [31:0] legal_list [9] = '{32'h0020F1B3, 32'h0020E1B3, 32'h0020C1B3, 32'h002091B3,
                                    32'h002081B3, 32'h00F0F093, 32'h00F0E093, 32'h00F0C093,
                                    32'h00309093};
    logic [31:0] bad_list [5] = '{32'h0020A1B3, 32'h4020F1B3, 32'h40309093, 32'h00008083,
                                  32'h00209463};

    initial begin
        int cyc, rws;
        rst_n = 1'b0; mem_ready = 1'b1; zero = 1'b1; instr = '0;
        #2;
        reset_pulse("power-on");

        add_instr(32'h00500093, 0, 0, 1, 0);
        run_queue(cyc, rws);
        check("addi cycles", cyc, 4);
        check("addi reg_write count", rws, 1);
        check("addi exec alu", {28'b0, last_exec_alu}, 32'h0);
        expect_fetch_next("addi back to fetch");

        add_instr(32'h40208033, 0, 0, 1, 0);
        run_queue(cyc, rws);
        check("sub cycles", cyc, 4);
        check("sub exec alu", {28'b0, last_exec_alu}, 32'h1);
        expect_fetch_next("sub back to fetch");

        add_instr(32'h00208463, 0, 0, 1, 0);
        run_queue(cyc, rws);
        check("beq taken cycles", cyc, 3);
        check("beq taken pc_write", {31'b0, last_branch_pcw}, 32'd1);
        expect_fetch_next("beq taken back to fetch");

        add_instr(32'h00208463, 0, 0, 0, 0);
        run_queue(cyc, rws);
        check("beq not taken cycles", cyc, 3);
        check("beq not taken pc_write", {31'b0, last_branch_pcw}, 32'd0);
        expect_fetch_next("beq not taken back to fetch");

        add_instr(32'h0000A083, 0, 2, 1, 0);
        run_queue(cyc, rws);
        check("lw 2-wait cycles", cyc, 7);
        check("lw reg_write count", rws, 1);
        expect_fetch_next("lw back to fetch");

        add_instr(32'h0020A023, 1, 1, 1, 0);
        run_queue(cyc, rws);
        check("sw stalled cycles", cyc, 6);
        check("sw reg_write count", rws, 0);
        expect_fetch_next("sw back to fetch");

        foreach (legal_list[i]) begin
            add_instr(legal_list[i], 0, 0, 1, 0);
            run_queue(cyc, rws);
            check($sformatf("alu instr %h cycles", legal_list[i]), cyc, 4);
        end
        check("slli exec alu", {28'b0, last_exec_alu}, 32'h5);

        foreach (bad_list[i]) begin
            add_instr(bad_list[i], 0, 0, 1, 3);
            run_queue(cyc, rws);
            reset_pulse($sformatf("trap %h", bad_list[i]));
        end

        add_instr(32'h0000007F, 0, 0, 1, 10);
        run_queue(cyc, rws);
        check("illegal opcode cycles", cyc, 12);
        check("illegal flag held", {31'b0, illegal}, 32'd1);
        reset_pulse("trap exit");

        add_instr(32'h0020A023, 0, 3, 1, 0);
        void'(q.pop_back());
        void'(q.pop_back());
        run_queue(cyc, rws);
        #1;
        check("sw stall mem_req before reset", {31'b0, mem_req}, 32'd1);
        check("sw stall state before reset", {28'b0, state}, 32'd5);
        rst_n = 1'b0;
        #1;
        check("mid-stall reset mem_req", {31'b0, mem_req}, 32'd0);
        check("mid-stall reset mem_we", {31'b0, mem_we}, 32'd0);
        check("mid-stall reset state", {28'b0, state}, 32'd0);
        reset_pulse("mid-stall");

        add_instr(32'h00500093, 0, 0, 1, 0);
        run_queue(cyc, rws);
        check("addi after reset cycles", cyc, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle control unit for the RV32I-subset datapath: sequences FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK, drives the ALU's 4-bit `alu_control` and consumes its `zero` flag. It is the driving end of the ALU control interface. It sits between the instruction register, the ALU and the unified memory port. Memory accesses use a req/ready handshake, so any access may stall.

## Interface
- `RESET_STATE`, default 4'd0 (FETCH): state entered on reset.
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `instr` in 32: instruction register contents, stable from the cycle after FETCH completes.
- `zero` in 1: ALU zero flag (`result == 0`).
- `mem_ready` in 1: memory completes the current request this cycle.
- `mem_req` out 1: memory access request.
- `mem_we` out 1: write qualifier for `mem_req`.
- `adr_src` out 1: address source (0 PC, 1 ALUOut).
- `ir_write` out 1: load IR and old-PC.
- `pc_write` out 1: load PC from the result mux.
- `reg_write` out 1: register-file write enable.
- `alu_src_a` out 2: ALU A source (00 PC, 01 old-PC, 10 reg A).
- `alu_src_b` out 2: ALU B source (00 reg B, 01 imm, 10 const 4).
- `result_src` out 2: result mux (00 ALUOut, 01 mem data, 10 ALU result).
- `alu_control` out 4: ALU operation code.
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLL.
- `illegal` out 1: trap indicator.
- `state` out 4: current state, for debug.

## Operation
- **Supported opcodes**
  - 0110011 R: add, sub, and, or, xor, sll.
  - 0010011 I: addi, andi, ori, xori, slli.
  - 0000011 lw (funct3 010).
  - 0100011 sw (funct3 010).
  - 1100011 beq (funct3 000).
- **ALU decode** from funct3 and instr[30]:
  - 000 → ADD, or SUB when R-type and instr[30]=1.
  - 111 AND, 110 OR, 100 XOR.
  - 001 SLL; funct7 must be 0.
  - Any other combination is illegal.
- **FETCH**: `mem_req`=1, adr_src=0, A=PC, B=4, ADD, result_src=10.
  - When `mem_ready`=1: `ir_write`=1 and `pc_write`=1, go to DECODE.
  - Otherwise hold FETCH with no write enables.
- **DECODE**: A=old-PC, B=imm, ADD (branch target into ALUOut).
  - lw/sw → MEM_ADR; R → EXEC_R; I → EXEC_I; beq → BRANCH; anything else → TRAP.
- **MEM_ADR**: A=regA, B=imm, ADD. lw → MEM_RD, sw → MEM_WR.
- **MEM_RD**: `mem_req`=1, adr_src=1. Wait for `mem_ready`, then go to MEM_WB.
- **MEM_WB**: result_src=01, `reg_write`=1, go to FETCH.
- **MEM_WR**: `mem_req`=1, `mem_we`=1, adr_src=1. Wait for `mem_ready`, then go to FETCH.
- **EXEC_R**: A=regA, B=regB, decoded op, go to ALU_WB.
- **EXEC_I**: A=regA, B=imm, decoded op, go to ALU_WB.
- **ALU_WB**: result_src=00, `reg_write`=1, go to FETCH.
- **BRANCH**: A=regA, B=regB, SUB, result_src=00.
  - `pc_write` = `zero`.
  - Go to FETCH unconditionally.
- **TRAP**: `illegal`=1, all enables 0. Exit only by reset.
- **Defaults**: any output not listed for a state is 0. `alu_control` defaults to ADD (0000).
- **Write enables**: `pc_write`, `ir_write`, `reg_write`, `mem_req` are never 1 outside the states listed above.

## Timing
- **Reset**: `rst_n` low asynchronously forces `state`=FETCH.
  - While `rst_n` is low, all enables and `illegal` are 0, with mux selects at FETCH values.
  - First `mem_req` appears in the first cycle after `rst_n` is sampled high.
  - Reset asserted mid-instruction abandons the instruction. No partial writes occur after the reset edge.
- **Output style**: outputs are combinational from `state` and `instr`. Exceptions:
  - `pc_write`/`ir_write` in FETCH also depend on `mem_ready`.
  - `pc_write` in BRANCH also depends on `zero`.
- **Cycle counts with zero-wait memory**:
  - R/I: 4 cycles. lw: 5. sw: 4. beq: 3.
  - Each wait cycle on `mem_ready` adds 1.
- **Handshake**: `mem_req` stays high with a constant address and `mem_we` until `mem_ready`. A `mem_ready` seen while `mem_req`=0 is ignored.
- **Branch timing**: `zero` is sampled only in BRANCH. Its value in other states has no effect.

## Structure
- **Package `cpu_pkg`**:
  - State enum: FETCH=0, DECODE=1, MEM_ADR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, EXEC_R=6, EXEC_I=7, ALU_WB=8, BRANCH=9, TRAP=10.
  - Opcode constants.
  - ALU op codes 0000–0101, shared with the ALU.
- **Sub-module `alu_decoder`** (combinational): maps opcode/funct3/instr[30]/funct7 to `alu_control` plus an `op_illegal` flag.
- **FSM**: one state register plus next-state and output logic.

## Test plan
- **addi**: `add x1,x0,5` style addi (0x00500093), `mem_ready` held 1.
  - States FETCH→DECODE→EXEC_I→ALU_WB→FETCH.
  - `alu_control`=0000 in EXEC_I; `reg_write`=1 exactly once.
- **sub**: 0x40208033. EXEC_R shows `alu_control`=0001.
- **beq taken vs not**: 0x00208463.
  - `zero`=1 in BRANCH → `pc_write`=1 in that cycle.
  - `zero`=0 → `pc_write`=0.
  - Both return to FETCH after 3 cycles.
- **lw with 2 wait cycles in MEM_RD**: 7 cycles total. `mem_req` and `adr_src`=1 stable during the wait; `reg_write` only in MEM_WB.
- **Illegal opcode**: 0x0000007F → TRAP with `illegal`=1. Stays there for 10 cycles with `mem_req`=0. `rst_n` pulse returns to FETCH.
- **Mid-stall reset**: `rst_n` asserted during a sw stall in MEM_WR → `mem_req`/`mem_we` drop immediately (asynchronously); `state`=FETCH.
